// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 host receiver.
//   PS2_DATA_BITS  payload bits per frame (LSB first on the wire)
//   ps2_state_e    receiver FSM states
//   odd_parity_ok  true when payload plus parity bit has odd weight
package ps2_pkg;

  localparam int PS2_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic                     pbit);
    return (^data ^ pbit) == 1'b1;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: synchronous byte FIFO for received PS/2 bytes.
// Ports:
//   clk_sys, reset      clock, synchronous active-high reset
//   push, push_data     write request and byte
//   pop                 read request (ignored while empty)
//   head                byte at the head, 0 while empty
//   empty, full         occupancy flags
//   overflow            push refused because the FIFO stayed full this cycle
module ps2_rx_fifo #(
  parameter int FIFO_BITS = 3
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_BITS;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_BITS:0] wptr, rptr;
  logic               pop_en, push_en;

  // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
  assign empty = (wptr == rptr);
  assign full  = (wptr[FIFO_BITS] != rptr[FIFO_BITS]) &&
                 (wptr[FIFO_BITS-1:0] == rptr[FIFO_BITS-1:0]);

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign pop_en   = pop & ~empty;
  assign push_en  = push & (~full | pop_en);
  assign overflow = push & full & ~pop_en;

  assign head = empty ? 8'h00 : mem[rptr[FIFO_BITS-1:0]];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_en) wptr <= wptr + 1'b1;
      if (pop_en)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define what is valid,
  // and leaving the array out of reset lets it map onto plain RAM.
  always_ff @(posedge clk_sys) begin
    if (push_en) mem[wptr[FIFO_BITS-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_host_rx.sv
// ps2_host_rx: core-side PS/2 receiver, one instance per channel.
// Ports:
//   clk_sys, reset       system clock, synchronous active-high reset
//   ps2_clk, ps2_data    asynchronous PS/2 pins
//   rx_data, rx_valid    FIFO head byte / FIFO not empty
//   rx_ack               pop the head byte
//   busy                 a frame is being received
//   parity_err           pulse: frame dropped for bad odd parity
//   frame_err            pulse: frame dropped for stop bit 0 or timeout
//   overflow             pulse: good byte dropped because the FIFO was full
module ps2_host_rx
  import ps2_pkg::*;
#(
  parameter int FILTER    = 8,
  parameter int TIMEOUT   = 2048,
  parameter int FIFO_BITS = 3
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       busy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FW  = $clog2(FILTER + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int BCW = $clog2(PS2_DATA_BITS);

  logic [1:0]               clk_sync, data_sync;
  logic [FW-1:0]            filt_cnt;
  logic                     filt_level, fall;
  logic [TW-1:0]            tcnt;
  logic                     timeout;
  ps2_state_e               state, state_n;
  logic [PS2_DATA_BITS-1:0] sreg, sreg_n;
  logic [BCW-1:0]           bitcnt, bitcnt_n;
  logic                     pbit, pbit_n;
  logic                     push_q, push_n, perr_n, ferr_n;
  logic                     fifo_empty, fifo_full;

  // Synchronisers idle high to match the released open-collector bus.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Glitch filter: the level follows the synchronised clock only after FILTER
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      filt_level <= 1'b1;
      filt_cnt   <= '0;
      fall       <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] != filt_level) begin
        if (filt_cnt == FW'(FILTER - 1)) begin
          filt_level <= clk_sync[1];
          filt_cnt   <= '0;
          fall       <= filt_level;  // strobe only on a 1->0 flip
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // A fall arriving in the expiry cycle keeps the frame alive.
  assign timeout = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tcnt <= '0;
    end else if (fall || state == IDLE) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n  = state;
    sreg_n   = sreg;
    bitcnt_n = bitcnt;
    pbit_n   = pbit;
    push_n   = 1'b0;
    perr_n   = 1'b0;
    ferr_n   = 1'b0;
    case (state)
      IDLE: begin
        // A high bit here is a false start and is silently ignored.
        if (fall && !data_sync[1]) begin
          state_n  = DATA;
          bitcnt_n = '0;
        end
      end
      DATA: begin
        if (fall) begin
          sreg_n   = {data_sync[1], sreg[PS2_DATA_BITS-1:1]};
          bitcnt_n = bitcnt + 1'b1;
          if (bitcnt == BCW'(PS2_DATA_BITS - 1)) state_n = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          pbit_n  = data_sync[1];
          state_n = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          // A bad stop bit outranks a parity error: one pulse per frame.
          if (!data_sync[1])                 ferr_n = 1'b1;
          else if (!odd_parity_ok(sreg, pbit)) perr_n = 1'b1;
          else                               push_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (timeout) begin
      state_n = IDLE;
      ferr_n  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      sreg       <= '0;
      bitcnt     <= '0;
      pbit       <= 1'b0;
      push_q     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      sreg       <= sreg_n;
      bitcnt     <= bitcnt_n;
      pbit       <= pbit_n;
      push_q     <= push_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
    end
  end

  assign busy = (state != IDLE);

  // sreg holds the finished byte while push_q is high: IDLE never shifts it.
  ps2_rx_fifo #(.FIFO_BITS(FIFO_BITS)) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (push_q),
    .push_data (sreg),
    .pop       (rx_ack),
    .head      (rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .overflow  (overflow)
  );

  assign rx_valid = ~fifo_empty;

endmodule

// File: tb/tb_ps2_host_rx.sv
// tb_ps2_host_rx: drives PS/2 frames into ps2_host_rx and scores the results
// against a queue-based model of the received byte stream.
module tb_ps2_host_rx;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 2048;
  localparam int FB      = 2;
  localparam int DEPTH   = 1 << FB;
  localparam int HALF    = 101;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       busy, parity_err, frame_err, overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_perr = 0, n_ferr = 0, n_ovf = 0, ferr_cyc = 0;
  int lat, last_fall_cyc;
  logic [7:0] exp_q[$];

  ps2_host_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .FIFO_BITS(FB)) dut (
    .clk_sys    (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .busy       (busy),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (parity_err) n_perr++;
    if (frame_err) begin
      n_ferr++;
      ferr_cyc = cyc;
    end
    if (overflow) n_ovf++;
  end

  // Wire frame: start 0, D0..D7, odd parity (optionally inverted), stop.
  function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par,
                                             input bit bad_stop);
    logic p;
    p = (~^d) ^ bad_par;
    return {~bad_stop, p, d, 1'b0};
  endfunction

  // Device side: data changes while the clock is high, clock low for HALF cycles.
  // Optionally pulses rx_ack so it is sampled on the push edge of the last bit.
  task automatic drive_bits(input logic [10:0] bits, input int nbits, input bit ack_at_push);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      #1;
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      for (int c = 1; c <= HALF; c++) begin
        @(posedge clk);
        #1;
        if (ack_at_push && i == nbits - 1) rx_ack = (c == FILTER + 3);
        if (i == nbits - 1 && lat < 0 && rx_valid) lat = c;
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  // Sends one frame, advances the model and scores pulses and FIFO head.
  task automatic send_and_score(input string name, input logic [7:0] d, input bit bad_par,
                                input bit bad_stop, input bit ack_at_push);
    int p0 = n_perr;
    int f0 = n_ferr;
    int o0 = n_ovf;
    int ep = 0, ef = 0, eo = 0;
    logic [7:0] head;
    lat = -1;
    drive_bits(make_frame(d, bad_par, bad_stop), 11, ack_at_push);
    if (ack_at_push && exp_q.size() > 0) void'(exp_q.pop_front());
    if (bad_stop) ef = 1;
    else if (bad_par) ep = 1;
    else if (exp_q.size() == DEPTH) eo = 1;
    else exp_q.push_back(d);
    head = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    n_cmp++;
    if (n_perr - p0 !== ep) begin
      n_bad++;
      $display("FAIL %s parity_err pulses: got %0d want %0d", name, n_perr - p0, ep);
    end
    n_cmp++;
    if (n_ferr - f0 !== ef) begin
      n_bad++;
      $display("FAIL %s frame_err pulses: got %0d want %0d", name, n_ferr - f0, ef);
    end
    n_cmp++;
    if (n_ovf - o0 !== eo) begin
      n_bad++;
      $display("FAIL %s overflow pulses: got %0d want %0d", name, n_ovf - o0, eo);
    end
    n_cmp++;
    if (rx_valid !== (exp_q.size() > 0) || rx_data !== head) begin
      n_bad++;
      $display("FAIL %s head: got valid=%b data=%h want valid=%b data=%h", name, rx_valid,
               rx_data, exp_q.size() > 0, head);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy after frame: got %b want 0", name, busy);
    end
  endtask

  task automatic pop_check(input string name);
    n_cmp++;
    if (exp_q.size() == 0) begin
      if (rx_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL %s pop on empty: got valid=%b want 0", name, rx_valid);
      end
      return;
    end
    if (rx_valid !== 1'b1 || rx_data !== exp_q[0]) begin
      n_bad++;
      $display("FAIL %s pop: got valid=%b data=%h want 1 %h", name, rx_valid, rx_data, exp_q[0]);
    end
    rx_ack = 1'b1;
    @(posedge clk);
    #1;
    rx_ack = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset outputs: got valid=%b data=%h busy=%b want 0 00 0", rx_valid,
               rx_data, busy);
    end
    n_cmp++;
    if (n_perr + n_ferr + n_ovf !== 0) begin
      n_bad++;
      $display("FAIL reset pulses: got %0d want 0", n_perr + n_ferr + n_ovf);
    end
  endtask

  task automatic test_basic();
    send_and_score("basic_1c", 8'h1C, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (lat !== FILTER + 4) begin
      n_bad++;
      $display("FAIL latency: got %0d want %0d", lat, FILTER + 4);
    end
    pop_check("basic_pop");
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic after ack: got valid=%b want 0", rx_valid);
    end
  endtask

  task automatic test_errors();
    send_and_score("parity_f0", 8'hF0, 1'b1, 1'b0, 1'b0);
    send_and_score("stop_55", 8'h55, 1'b0, 1'b1, 1'b0);
    send_and_score("good_55", 8'h55, 1'b0, 1'b0, 1'b0);
    pop_check("good_55_pop");
  endtask

  task automatic test_timeout();
    int f0 = n_ferr;
    int p0 = n_perr;
    int dt;
    drive_bits(make_frame(8'hA5, 1'b0, 1'b0), 5, 1'b0);
    repeat (3000) @(posedge clk);
    #1;
    dt = ferr_cyc - last_fall_cyc;
    n_cmp++;
    if (n_ferr - f0 !== 1 || n_perr !== p0) begin
      n_bad++;
      $display("FAIL timeout pulses: got ferr=%0d perr=%0d want 1 0", n_ferr - f0, n_perr - p0);
    end
    n_cmp++;
    if (dt < TIMEOUT || dt > TIMEOUT + FILTER + 8) begin
      n_bad++;
      $display("FAIL timeout delay: got %0d want %0d..%0d", dt, TIMEOUT, TIMEOUT + FILTER + 8);
    end
    n_cmp++;
    if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout state: got busy=%b valid=%b want 0 0", busy, rx_valid);
    end
    send_and_score("after_timeout_aa", 8'hAA, 1'b0, 1'b0, 1'b0);
    pop_check("after_timeout_pop");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) send_and_score("ovf_fill", 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) pop_check("ovf_drain");
    for (int i = 0; i < DEPTH; i++) send_and_score("full_fill", 8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
    send_and_score("full_push_pop", 8'h15, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) pop_check("full_drain");
  endtask

  task automatic test_glitch();
    int p0 = n_perr + n_ferr + n_ovf;
    bit seen = 1'b0;
    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (busy) seen = 1'b1;
    end
    n_cmp++;
    if (seen || n_perr + n_ferr + n_ovf !== p0) begin
      n_bad++;
      $display("FAIL glitch: got busy_seen=%b pulses=%0d want 0 0", seen,
               n_perr + n_ferr + n_ovf - p0);
    end
  endtask

  task automatic test_reset_midframe();
    int p0;
    send_and_score("pre_reset_c3", 8'hC3, 1'b0, 1'b0, 1'b0);
    drive_bits(make_frame(8'h3C, 1'b0, 1'b0), 5, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midframe busy: got %b want 1", busy);
    end
    p0 = n_perr + n_ferr + n_ovf;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    n_cmp++;
    if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midframe reset: got busy=%b valid=%b want 0 0", busy, rx_valid);
    end
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (n_perr + n_ferr + n_ovf !== p0) begin
      n_bad++;
      $display("FAIL midframe reset pulses: got %0d want 0", n_perr + n_ferr + n_ovf - p0);
    end
    send_and_score("after_reset_7e", 8'h7E, 1'b0, 1'b0, 1'b0);
    pop_check("after_reset_pop");
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic [7:0] d = 8'($urandom);
      int kind = $urandom_range(0, 9);
      int pops = $urandom_range(0, 2);
      send_and_score("random", d, kind == 7 || kind == 8, kind == 9, 1'b0);
      for (int k = 0; k < pops; k++) pop_check("random_pop");
    end
    while (exp_q.size() > 0) pop_check("random_drain");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_timeout();
    test_overflow();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
